// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: reads instruction memory at PC through a req/valid
// handshake, latches the returned word into INSTRUCTION and advances PC.
// Optional feature macro: FETCH_TIMEOUT_EN. When defined, a fetch left waiting
// TIMEOUT_CYCLES cycles completes with a NOP and sets the sticky FETCH_ERR flag.
// Without it, WAIT never times out and FETCH_ERR is tied low.
module instr_fetch_unit #(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  FETCH,
    input  logic                  PC_LOAD,
    input  logic [ADDR_WIDTH-1:0] PC_LOAD_VALUE,
    output logic [ADDR_WIDTH-1:0] IMEM_ADDR,
    output logic                  IMEM_REQ,
    input  logic [DATA_WIDTH-1:0] IMEM_RDATA,
    input  logic                  IMEM_VALID,
    output logic [DATA_WIDTH-1:0] INSTRUCTION,
    output logic [ADDR_WIDTH-1:0] PC,
    output logic                  BUSY,
    output logic                  INSTR_VALID,
    output logic                  FETCH_ERR
);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;       // address of the fetch in flight
    logic                  pc_loaded_q;  // a jump arrived mid-fetch; keep it over A+1

    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic [ADDR_WIDTH-1:0] next_addr;

    assign fetch_addr = PC_LOAD ? PC_LOAD_VALUE : PC;
    assign next_addr  = addr_q + ADDR_WIDTH'(1);

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DATA_WIDTH-1:0] NOP_OPCODE = DATA_WIDTH'(5);
    logic [CNT_W-1:0] cnt_q;
`else
    assign FETCH_ERR = 1'b0;
`endif

    // Fetch sequencer: state, address, PC, instruction register and all outputs.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            pc_loaded_q <= 1'b0;
            PC          <= RESET_PC;
            INSTRUCTION <= '0;
            IMEM_ADDR   <= '0;
            IMEM_REQ    <= 1'b0;
            BUSY        <= 1'b0;
            INSTR_VALID <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt_q       <= '0;
            FETCH_ERR   <= 1'b0;
`endif
        end else begin
            IMEM_REQ    <= 1'b0;
            INSTR_VALID <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (PC_LOAD) PC <= PC_LOAD_VALUE;
                    if (FETCH) begin
                        addr_q      <= fetch_addr;
                        IMEM_ADDR   <= fetch_addr;
                        IMEM_REQ    <= 1'b1;
                        BUSY        <= 1'b1;
                        pc_loaded_q <= 1'b0;
                        state_q     <= StReq;
`ifdef FETCH_TIMEOUT_EN
                        cnt_q       <= '0;
`endif
                    end
                end
                StReq: begin
                    // IMEM_VALID is deliberately ignored here.
                    if (PC_LOAD) begin
                        PC          <= PC_LOAD_VALUE;
                        pc_loaded_q <= 1'b1;
                    end
                    state_q <= StWait;
                end
                StWait: begin
                    if (PC_LOAD) begin
                        PC          <= PC_LOAD_VALUE;
                        pc_loaded_q <= 1'b1;
                    end
                    if (IMEM_VALID) begin
                        INSTRUCTION <= IMEM_RDATA;
                        if (!PC_LOAD && !pc_loaded_q) PC <= next_addr;
                        INSTR_VALID <= 1'b1;
                        BUSY        <= 1'b0;
                        state_q     <= StIdle;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        INSTRUCTION <= NOP_OPCODE;
                        if (!PC_LOAD && !pc_loaded_q) PC <= next_addr;
                        FETCH_ERR   <= 1'b1;
                        INSTR_VALID <= 1'b1;
                        BUSY        <= 1'b0;
                        state_q     <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed and randomized fetches
// against a transaction-level model of PC, instruction register and error flag.
module tb_instr_fetch_unit;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b1;
    logic       FETCH = 1'b0;
    logic       PC_LOAD = 1'b0;
    logic [7:0] PC_LOAD_VALUE = '0;
    logic [7:0] IMEM_ADDR;
    logic       IMEM_REQ;
    logic [7:0] IMEM_RDATA = '0;
    logic       IMEM_VALID = 1'b0;
    logic [7:0] INSTRUCTION;
    logic [7:0] PC;
    logic       BUSY;
    logic       INSTR_VALID;
    logic       FETCH_ERR;

    instr_fetch_unit dut (
        .CLOCK        (CLOCK),
        .RESET        (RESET),
        .FETCH        (FETCH),
        .PC_LOAD      (PC_LOAD),
        .PC_LOAD_VALUE(PC_LOAD_VALUE),
        .IMEM_ADDR    (IMEM_ADDR),
        .IMEM_REQ     (IMEM_REQ),
        .IMEM_RDATA   (IMEM_RDATA),
        .IMEM_VALID   (IMEM_VALID),
        .INSTRUCTION  (INSTRUCTION),
        .PC           (PC),
        .BUSY         (BUSY),
        .INSTR_VALID  (INSTR_VALID),
        .FETCH_ERR    (FETCH_ERR)
    );

    always #5 CLOCK = ~CLOCK;

    int tests = 0;
    int fails = 0;

    // Reference model: architectural state only.
    logic [7:0] mem [256];
    logic [7:0] m_pc;
    logic [7:0] m_instr;
    logic       m_err;

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pc"}, PC, 8'h00);
        check({tag, "_instr"}, INSTRUCTION, 8'h00);
        check({tag, "_addr"}, IMEM_ADDR, 8'h00);
        check({tag, "_req"}, IMEM_REQ, 0);
        check({tag, "_busy"}, BUSY, 0);
        check({tag, "_ivalid"}, INSTR_VALID, 0);
        check({tag, "_err"}, FETCH_ERR, 0);
    endtask

    // One complete fetch. lat = WAIT cycles before IMEM_VALID; ld_done jumps on the
    // completion edge.
    task automatic do_fetch(input bit ld, input logic [7:0] lv, input int lat,
                            input bit ld_done, input logic [7:0] lv2);
        logic [7:0] a;
        int busy_n;
        int req_n;
        a      = ld ? lv : m_pc;
        busy_n = 0;
        req_n  = 0;
        FETCH = 1'b1; PC_LOAD = ld; PC_LOAD_VALUE = lv;
        tick();
        FETCH = 1'b0; PC_LOAD = 1'b0;
        if (ld) m_pc = lv;
        check("req_addr", IMEM_ADDR, a);
        check("req_pulse", IMEM_REQ, 1);
        check("req_pc", PC, m_pc);
        busy_n += int'(BUSY); req_n += int'(IMEM_REQ);
        // stray response during REQ and a repeated FETCH must both be ignored
        IMEM_VALID = 1'($urandom_range(0, 1)); IMEM_RDATA = ~mem[a]; FETCH = 1'b1;
        tick();
        IMEM_VALID = 1'b0; FETCH = 1'b0;
        busy_n += int'(BUSY); req_n += int'(IMEM_REQ);
        for (int i = 0; i < lat; i++) begin
            FETCH = 1'($urandom_range(0, 1));
            tick();
            FETCH = 1'b0;
            busy_n += int'(BUSY); req_n += int'(IMEM_REQ);
        end
        IMEM_VALID = 1'b1; IMEM_RDATA = mem[a]; PC_LOAD = ld_done; PC_LOAD_VALUE = lv2;
        tick();
        IMEM_VALID = 1'b0; PC_LOAD = 1'b0;
        m_instr = mem[a];
        m_pc    = ld_done ? lv2 : a + 8'd1;
        check("done_instr", INSTRUCTION, m_instr);
        check("done_pc", PC, m_pc);
        check("done_ivalid", INSTR_VALID, 1);
        check("done_busy", BUSY, 0);
        check("done_addr_hold", IMEM_ADDR, a);
        check("busy_cycles", busy_n, lat + 2);
        check("req_count", req_n, 1);
        check("err_flag", FETCH_ERR, m_err);
        tick();
        check("ivalid_pulse", INSTR_VALID, 0);
        check("instr_hold", INSTRUCTION, m_instr);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        m_pc = 8'h00; m_instr = 8'h00; m_err = 1'b0;

        // Reset state
        tick(); tick();
        check_reset_state("reset");
        RESET = 1'b0;
        tick();

        // Zero-wait fetch from address 0
        mem[8'h00] = 8'h07;
        do_fetch(0, 8'h00, 0, 0, 8'h00);
        check("first_pc", PC, 8'h01);

        // Three wait cycles
        mem[8'h01] = 8'h1F;
        do_fetch(0, 8'h00, 3, 0, 8'h00);

        // Jump together with FETCH
        do_fetch(1, 8'h40, 1, 0, 8'h00);
        check("jump_pc", PC, 8'h41);

        // PC_LOAD alone in IDLE, then fetch at 0xFF wraps PC
        PC_LOAD = 1'b1; PC_LOAD_VALUE = 8'hFF;
        tick();
        PC_LOAD = 1'b0;
        m_pc = 8'hFF;
        check("idle_load_pc", PC, 8'hFF);
        check("idle_load_busy", BUSY, 0);
        mem[8'hFF] = 8'h20;
        do_fetch(0, 8'h00, 0, 0, 8'h00);
        check("wrap_pc", PC, 8'h00);
        check("wrap_instr", INSTRUCTION, 8'h20);

        // Response while IDLE is ignored
        IMEM_VALID = 1'b1; IMEM_RDATA = ~m_instr;
        tick();
        IMEM_VALID = 1'b0;
        check("idle_valid_instr", INSTRUCTION, m_instr);
        check("idle_valid_ivalid", INSTR_VALID, 0);
        check("idle_valid_pc", PC, m_pc);

        // Jump on the completion edge overrides A+1
        do_fetch(0, 8'h00, 2, 1, 8'h80);
        check("done_jump_pc", PC, 8'h80);

        // Randomized fetches
        for (int n = 0; n < 20; n++) begin
            do_fetch(1'($urandom_range(0, 3) == 0), 8'($urandom), int'($urandom_range(0, 6)),
                     1'($urandom_range(0, 4) == 0), 8'($urandom));
        end

`ifdef FETCH_TIMEOUT_EN
        // Timeout after 15 WAIT cycles without a response
        begin
            logic [7:0] a;
            a = m_pc;
            FETCH = 1'b1;
            tick();
            FETCH = 1'b0;
            tick();
            repeat (14) tick();
            check("to_busy_before", BUSY, 1);
            check("to_ivalid_before", INSTR_VALID, 0);
            tick();
            m_instr = 8'h05; m_pc = a + 8'd1; m_err = 1'b1;
            check("to_instr", INSTRUCTION, m_instr);
            check("to_pc", PC, m_pc);
            check("to_err", FETCH_ERR, 1);
            check("to_ivalid", INSTR_VALID, 1);
            check("to_busy", BUSY, 0);
            tick();
        end
        do_fetch(0, 8'h00, 1, 0, 8'h00);
        check("err_sticky", FETCH_ERR, 1);
`else
        // No timeout: a long wait still completes normally
        do_fetch(0, 8'h00, 30, 0, 8'h00);
        check("no_err", FETCH_ERR, 0);
`endif

        // Reset during WAIT aborts; a late response is ignored
        FETCH = 1'b1;
        tick();
        FETCH = 1'b0;
        tick();
        check("pre_reset_busy", BUSY, 1);
        #2 RESET = 1'b1;
        #1;
        check_reset_state("async_reset");
        tick();
        RESET = 1'b0;
        IMEM_VALID = 1'b1; IMEM_RDATA = 8'hAA;
        tick();
        IMEM_VALID = 1'b0;
        m_pc = 8'h00; m_instr = 8'h00; m_err = 1'b0;
        check_reset_state("late_resp");

        // Normal operation after reset
        do_fetch(0, 8'h00, 1, 0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
